// File: rtl/mipi_csi2_pkg.sv
// Shared CSI-2 definitions: data-type codes, depacketizer state and output
// bundle, and the packet-header ECC used by the depacketizer and its consumers.
package mipi_csi2_pkg;

   localparam logic [5:0] DT_FS    = 6'h00;
   localparam logic [5:0] DT_FE    = 6'h01;
   localparam logic [5:0] DT_LS    = 6'h02;
   localparam logic [5:0] DT_LE    = 6'h03;
   localparam logic [5:0] DT_RAW8  = 6'h2A;
   localparam logic [5:0] DT_RAW10 = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HDR      = 2'd1,
      ST_PAYLOAD  = 2'd2,
      ST_WAIT_EOT = 2'd3
   } csi2_state_e;

   typedef struct packed {
      logic        frame_start;
      logic        frame_end;
      logic        line_start;
      logic        line_end;
      logic [15:0] sync_wc;
      logic [5:0]  data_type;
      logic [1:0]  vc;
      logic [15:0] word_count;
      logic [15:0] data;
      logic [1:0]  data_keep;
      logic        data_valid;
      logic        data_last;
      logic        ecc_err;
      logic        pkt_err;
   } csi2_out_t;

   // Hamming-style ECC over {WC_hi, WC_lo, DI}; d[0] is DI bit 0.
   function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13]
           ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14]
           ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
      p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15]
           ^ d[18] ^ d[20] ^ d[21] ^ d[22];
      p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15]
           ^ d[19] ^ d[20] ^ d[21] ^ d[23];
      p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18]
           ^ d[19] ^ d[20] ^ d[22] ^ d[23];
      p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17]
           ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
      return p;
   endfunction

endpackage

// File: rtl/mipi_csi2_ecc.sv
// Combinational 24-to-6 parity tree producing the CSI-2 packet-header ECC.
module mipi_csi2_ecc
   import mipi_csi2_pkg::*;
(
   input  logic [23:0] data_i,
   output logic [5:0]  ecc_o
);

   assign ecc_o = csi2_ecc(data_i);

endmodule

// File: rtl/mipi_csi2_depacketizer.sv
// Splits the 2-lane byte stream into CSI-2 packets: checks header ECC, turns
// short packets into sync pulses and streams long-packet payload 16 bits/beat.
module mipi_csi2_depacketizer
   import mipi_csi2_pkg::*;
#(
   parameter logic [3:0] VC_MASK = 4'b1111
) (
   input  logic        clk_in,
   input  logic        reset_n,
   input  logic        lane_valid,
   input  logic [15:0] lane_data,
   output logic        frame_start,
   output logic        frame_end,
   output logic        line_start,
   output logic        line_end,
   output logic [15:0] sync_wc,
   output logic [5:0]  data_type,
   output logic [1:0]  vc,
   output logic [15:0] word_count,
   output logic [15:0] data,
   output logic [1:0]  data_keep,
   output logic        data_valid,
   output logic        data_last,
   output logic        ecc_err,
   output logic        pkt_err
);

   csi2_state_e state_q, state_d;
   csi2_out_t   out_q, out_d;
   logic [7:0]  di_q, di_d;
   logic [7:0]  wc_lo_q, wc_lo_d;
   logic [15:0] rem_q, rem_d;
   logic        armed_q;

   logic [5:0]  ecc_calc_s;
   logic        ecc_ok_s;
   logic        vc_ok_s;
   logic        short_s;
   logic [15:0] wc_s;

   assign wc_s     = {lane_data[7:0], wc_lo_q};
   assign ecc_ok_s = (ecc_calc_s == lane_data[13:8]) && (lane_data[15:14] == 2'b00);
   assign vc_ok_s  = VC_MASK[di_q[7:6]];
   assign short_s  = (di_q[5:4] == 2'b00);

   mipi_csi2_ecc u_ecc (
      .data_i ({lane_data[7:0], wc_lo_q, di_q}),
      .ecc_o  (ecc_calc_s)
   );

   // State register; armed_q means lane_valid was low last cycle, so a burst
   // already in flight at reset release is never decoded.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= ~lane_valid;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (lane_valid) begin
               state_d = armed_q ? ST_HDR : ST_WAIT_EOT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (!lane_valid) begin
               state_d = ST_IDLE;
            end else if (!ecc_ok_s || !vc_ok_s || short_s || (wc_s == 16'd0)) begin
               state_d = ST_WAIT_EOT;
            end else begin
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (!lane_valid) begin
               state_d = ST_IDLE;
            end else if (rem_q <= 16'd2) begin
               state_d = ST_WAIT_EOT;
            end else begin
               state_d = ST_PAYLOAD;
            end
         end
         ST_WAIT_EOT: begin
            if (lane_valid) begin
               state_d = ST_WAIT_EOT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values; pulses and data_valid default low each cycle.
   always_comb begin
      out_d            = out_q;
      out_d.frame_start = 1'b0;
      out_d.frame_end   = 1'b0;
      out_d.line_start  = 1'b0;
      out_d.line_end    = 1'b0;
      out_d.data_valid  = 1'b0;
      out_d.data_last   = 1'b0;
      out_d.data_keep   = 2'b00;
      out_d.ecc_err     = 1'b0;
      out_d.pkt_err     = 1'b0;
      di_d    = di_q;
      wc_lo_d = wc_lo_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (lane_valid && armed_q) begin
               di_d    = lane_data[7:0];
               wc_lo_d = lane_data[15:8];
            end else begin
               di_d    = di_q;
            end
         end
         ST_HDR: begin
            if (!lane_valid) begin
               out_d.pkt_err = 1'b1;
            end else if (!ecc_ok_s) begin
               out_d.ecc_err = 1'b1;
            end else if (!vc_ok_s) begin
               out_d.ecc_err = 1'b0;
            end else begin
               out_d.data_type = di_q[5:0];
               out_d.vc        = di_q[7:6];
               if (short_s) begin
                  out_d.sync_wc = wc_s;
                  case (di_q[5:0])
                     DT_FS:   out_d.frame_start = 1'b1;
                     DT_FE:   out_d.frame_end   = 1'b1;
                     DT_LS:   out_d.line_start  = 1'b1;
                     DT_LE:   out_d.line_end    = 1'b1;
                     default: out_d.frame_start = 1'b0;
                  endcase
               end else begin
                  out_d.word_count = wc_s;
                  rem_d            = wc_s;
               end
            end
         end
         ST_PAYLOAD: begin
            if (!lane_valid) begin
               out_d.pkt_err = 1'b1;
               rem_d         = 16'd0;
            end else if (rem_q >= 16'd2) begin
               out_d.data_valid = 1'b1;
               out_d.data       = lane_data;
               out_d.data_keep  = 2'b11;
               out_d.data_last  = (rem_q == 16'd2);
               rem_d            = rem_q - 16'd2;
            end else begin
               // Odd WC: upper lane already carries the first CRC byte, so blank it.
               out_d.data_valid = 1'b1;
               out_d.data       = {8'h00, lane_data[7:0]};
               out_d.data_keep  = 2'b01;
               out_d.data_last  = 1'b1;
               rem_d            = 16'd0;
            end
         end
         ST_WAIT_EOT: begin
            rem_d = rem_q;
         end
         default: begin
            rem_d = 16'd0;
         end
      endcase
   end

   // Registered outputs and header/payload bookkeeping
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         out_q   <= '0;
         di_q    <= 8'h00;
         wc_lo_q <= 8'h00;
         rem_q   <= 16'd0;
      end else begin
         out_q   <= out_d;
         di_q    <= di_d;
         wc_lo_q <= wc_lo_d;
         rem_q   <= rem_d;
      end
   end

   assign frame_start = out_q.frame_start;
   assign frame_end   = out_q.frame_end;
   assign line_start  = out_q.line_start;
   assign line_end    = out_q.line_end;
   assign sync_wc     = out_q.sync_wc;
   assign data_type   = out_q.data_type;
   assign vc          = out_q.vc;
   assign word_count  = out_q.word_count;
   assign data        = out_q.data;
   assign data_keep   = out_q.data_keep;
   assign data_valid  = out_q.data_valid;
   assign data_last   = out_q.data_last;
   assign ecc_err     = out_q.ecc_err;
   assign pkt_err     = out_q.pkt_err;

endmodule

// File: doc/mipi_csi2_depacketizer.md
# mipi_csi2_depacketizer

Receives the byte-aligned 2-lane CSI-2 stream from the IMX219 once the sensor is streaming (mode 2), and splits it into packets. Header ECC is checked on every packet. Short packets become frame/line sync pulses. Long-packet payload is emitted as a 16-bit byte-enabled stream to the downstream pixel unpacker. It sits between the D-PHY lane aligner and the RAW8/RAW10 unpacker; the `imx219` controller's `format` selects which data type the unpacker expects.

## Interface
- `VC_MASK`, default 4'b1111: bit n set accepts virtual channel n. Packets on other channels are dropped silently.
- `clk_in`  input  1  byte clock from the lane aligner
- `reset_n`  input  1  asynchronous, active-low reset
- `lane_valid`  input  1  high for the whole burst; sync bytes are already stripped
- `lane_data`  input  16  [7:0] = lane 0 byte (even packet byte), [15:8] = lane 1 byte (odd packet byte)
- `frame_start`, `frame_end`, `line_start`, `line_end`  output  1 each  one-cycle pulses for short DT 0x00/0x01/0x02/0x03
- `sync_wc`  output  16  WC field (frame/line number) of the last short packet
- `data_type`  output  6  DT of the current or last accepted packet
- `vc`  output  2  virtual channel of the current or last accepted packet
- `word_count`  output  16  WC of the current long packet
- `data`  output  16  payload bytes, same lane mapping as `lane_data`
- `data_keep`  output  2  byte enables; 2'b01 appears only on an odd-WC last beat
- `data_valid`  output  1  payload beat present
- `data_last`  output  1  final payload beat of a packet
- `ecc_err`  output  1  one-cycle pulse: header ECC mismatch, packet dropped
- `pkt_err`  output  1  one-cycle pulse: `lane_valid` fell before the payload completed

## Operation
- States: IDLE, HDR, PAYLOAD, WAIT_EOT.
- **IDLE:** when `lane_valid`=1, latch DI = lane 0 and WC_lo = lane 1, then go to HDR.
- **HDR:** WC_hi = lane 0, ECC = lane 1. Compute the 6-bit CSI-2 Hamming ECC over {WC_hi, WC_lo, DI}, where D0 = DI[0]. Received ECC[7:6] must be 0.
  - ECC mismatch: pulse `ecc_err`, go to WAIT_EOT.
  - VC not in `VC_MASK`: go to WAIT_EOT with no output.
  - DT ≤ 0x0F (short packet): update `sync_wc`. DT 0x00–0x03 pulses the matching sync output; other short DTs produce no pulse. Go to WAIT_EOT.
  - DT ≥ 0x10 (long packet): load `word_count` and the remaining-byte counter. WC = 0 goes to WAIT_EOT with no beats; otherwise go to PAYLOAD.
- **PAYLOAD:** each `lane_valid` cycle emits one beat and decrements the remaining count by min(2, remaining).
  - The beat with remaining ≤ 2 sets `data_last`. Its `data_keep` is 2'b11 when remaining = 2 and 2'b01 when remaining = 1.
  - After the last beat, go to WAIT_EOT. The footer CRC and trailer bytes are consumed there and not checked.
- **WAIT_EOT:** stay until `lane_valid`=0, then go to IDLE. A new packet always requires `lane_valid` to go low first.
- **`lane_valid` falls in HDR or PAYLOAD:** pulse `pkt_err`, do not emit `data_last`, go to IDLE.
- **Reset:** all outputs are 0 and the state is IDLE. Asserting reset mid-packet discards the packet. After release, the block waits for `lane_valid` low and then high again; a burst that is already high at release is treated as WAIT_EOT.

## Timing
- Every output is registered.
- Sync pulses, `ecc_err`, `data_type`, `vc` and `word_count` update one cycle after the HDR input cycle.
- A payload beat appears one cycle after its input cycle.
- `pkt_err` fires one cycle after the first `lane_valid`=0 sample in HDR or PAYLOAD.
- Pulses last exactly one cycle. `data_valid` is never asserted in the same cycle as a sync pulse.
- No backpressure: the consumer must accept one beat per cycle.
- For a WC = N long packet, exactly ceil(N/2) beats are emitted.

## Structure
- Shared package `mipi_csi2_pkg` holds:
  - the DT constants: FS = 0x00, FE = 0x01, LS = 0x02, LE = 0x03, RAW8 = 0x2A, RAW10 = 0x2B;
  - the state enum;
  - the `csi2_ecc(input [23:0])` function, which the unpacker and testbenches reuse.
- One sub-module, `mipi_csi2_ecc`: a combinational 24→6 parity tree wrapping `csi2_ecc`. Its six parity bits are:
  - P0 = D0^D1^D2^D4^D5^D7^D10^D11^D13^D16^D20^D21^D22^D23
  - P1 = D0^D1^D3^D4^D6^D8^D10^D12^D14^D17^D20^D21^D22^D23
  - P2 = D0^D2^D3^D5^D6^D9^D11^D12^D15^D18^D20^D21^D22
  - P3 = D1^D2^D3^D7^D8^D9^D13^D14^D15^D19^D20^D21^D23
  - P4 = D4^D5^D6^D7^D8^D9^D16^D17^D18^D19^D20^D22^D23
  - P5 = D10^D11^D12^D13^D14^D15^D16^D17^D18^D19^D21^D22^D23

## Test plan
- **Frame start:** burst {00,00},{00,00} → one `frame_start` pulse, `sync_wc`=0x0000, `vc`=0, no `data_valid`.
- **Even-WC long packet:** burst {2B,04},{00,34},{11,22},{33,44},{CRC,CRC} → beats 0x2211/2'b11 then 0x4433/2'b11 with `data_last`; `data_type`=0x2B, `word_count`=4.
- **Odd-WC long packet:** DT 0x2A, WC=3 with correct ECC → two beats, the last with `data_keep`=2'b01 and `data_last`; CRC bytes are not emitted.
- **Corrupt ECC:** flip ECC bit 0 of the previous packet → `ecc_err` pulses once, no beats; the next burst decodes normally.
- **Truncated burst:** `lane_valid` drops after the first payload beat of a WC=4 packet → `pkt_err` pulses, no `data_last`, state returns to IDLE.
- **VC filter and reset:** `VC_MASK`=4'b0001 with a packet on VC1 → no outputs at all. Reset asserted mid-payload → outputs clear immediately; after release, a still-high `lane_valid` burst produces nothing.
